// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU response checker: opcodes, widths and the tap bundle.
package alsu_pkg;

  localparam int unsigned OUT_W = 6;
  localparam int unsigned LED_W = 16;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] opcode;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_op_a;
    logic       red_op_b;
    logic       bypass_a;
    logic       bypass_b;
  } alsu_in_t;

endpackage

// File: rtl/alsu_ref_model.sv
// Cycle-accurate ALSU model: input register stage followed by the out/leds register stage.
module alsu_ref_model
  import alsu_pkg::*;
#(
  parameter bit PRIO_A   = 1'b1,
  parameter bit FULL_ADD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  alsu_in_t         i_taps,
  output logic [OUT_W-1:0] o_exp_out,
  output logic [LED_W-1:0] o_exp_leds,
  output logic [2:0]       o_exp_op
);

  alsu_in_t         r_in;
  logic [OUT_W-1:0] r_exp_out;
  logic [LED_W-1:0] r_exp_leds;
  logic [2:0]       r_exp_op;

  logic             w_red;
  logic             w_invalid;
  logic             w_pick_a_red;
  logic             w_pick_a_byp;
  logic [OUT_W-1:0] w_nxt_out;
  logic [LED_W-1:0] w_nxt_leds;

  assign w_red        = r_in.red_op_a | r_in.red_op_b;
  assign w_invalid    = (r_in.opcode > OP_ROT) | (w_red & (r_in.opcode > OP_XOR));
  assign w_pick_a_red = r_in.red_op_a & (~r_in.red_op_b | PRIO_A);
  assign w_pick_a_byp = r_in.bypass_a & (~r_in.bypass_b | PRIO_A);

  // Next out/leds; invalid beats bypass, bypass beats the opcode.
  always_comb begin
    w_nxt_out  = r_exp_out;
    w_nxt_leds = '0;
    if (w_invalid) begin
      w_nxt_out  = '0;
      w_nxt_leds = ~r_exp_leds;
    end else if (r_in.bypass_a | r_in.bypass_b) begin
      w_nxt_out = OUT_W'(w_pick_a_byp ? r_in.a : r_in.b);
    end else begin
      case (r_in.opcode)
        OP_AND: begin
          if (w_red) w_nxt_out = OUT_W'(w_pick_a_red ? (&r_in.a) : (&r_in.b));
          else       w_nxt_out = OUT_W'(r_in.a & r_in.b);
        end
        OP_XOR: begin
          if (w_red) w_nxt_out = OUT_W'(w_pick_a_red ? (^r_in.a) : (^r_in.b));
          else       w_nxt_out = OUT_W'(r_in.a ^ r_in.b);
        end
        OP_ADD:   w_nxt_out = OUT_W'(r_in.a) + OUT_W'(r_in.b) + OUT_W'(FULL_ADD & r_in.cin);
        OP_MUL:   w_nxt_out = OUT_W'(r_in.a) * OUT_W'(r_in.b);
        OP_SHIFT: w_nxt_out = r_in.direction ? {r_exp_out[OUT_W-2:0], r_in.serial_in}
                                             : {r_in.serial_in, r_exp_out[OUT_W-1:1]};
        OP_ROT:   w_nxt_out = r_in.direction ? {r_exp_out[OUT_W-2:0], r_exp_out[OUT_W-1]}
                                             : {r_exp_out[0], r_exp_out[OUT_W-1:1]};
        default:  w_nxt_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in       <= '0;
      r_exp_out  <= '0;
      r_exp_leds <= '0;
      r_exp_op   <= '0;
    end else begin
      r_in       <= i_taps;
      r_exp_out  <= w_nxt_out;
      r_exp_leds <= w_nxt_leds;
      r_exp_op   <= r_in.opcode;
    end
  end

  assign o_exp_out  = r_exp_out;
  assign o_exp_leds = r_exp_leds;
  assign o_exp_op   = r_exp_op;

endmodule

// File: rtl/alsu_checker.sv
// ALSU response checker: runs the reference model beside the ALSU and counts compares/mismatches.
module alsu_checker
  import alsu_pkg::*;
#(
  parameter string       INPUT_PRIORITY = "A",
  parameter string       FULL_ADDER     = "ON",
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       A,
  input  logic [2:0]       B,
  input  logic [2:0]       opcode,
  input  logic             cin,
  input  logic             serial_in,
  input  logic             direction,
  input  logic             red_op_A,
  input  logic             red_op_B,
  input  logic             bypass_A,
  input  logic             bypass_B,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [LED_W-1:0] dut_leds,
  output logic             mismatch,
  output logic             sticky_err,
  output logic [2:0]       first_err_op,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam bit               PRIO_A   = (INPUT_PRIORITY == "A");
  localparam bit               FULL_ADD = (FULL_ADDER == "ON");
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  alsu_in_t         w_taps;
  logic [OUT_W-1:0] w_exp_out;
  logic [LED_W-1:0] w_exp_leds;
  logic [2:0]       w_exp_op;
  logic [1:0]       r_vld;
  logic             w_cmp;
  logic             w_fail;

  assign w_taps = '{a: A, b: B, opcode: opcode, cin: cin, serial_in: serial_in,
                    direction: direction, red_op_a: red_op_A, red_op_b: red_op_B,
                    bypass_a: bypass_A, bypass_b: bypass_B};

  alsu_ref_model #(
    .PRIO_A   (PRIO_A),
    .FULL_ADD (FULL_ADD)
  ) u_model (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_taps     (w_taps),
    .o_exp_out  (w_exp_out),
    .o_exp_leds (w_exp_leds),
    .o_exp_op   (w_exp_op)
  );

  assign w_cmp  = r_vld[1];
  assign w_fail = (dut_out != w_exp_out) | (dut_leds != w_exp_leds);

  // Valid pipe, saturating counters and first-error capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld        <= '0;
      mismatch     <= 1'b0;
      sticky_err   <= 1'b0;
      first_err_op <= '0;
      chk_cnt      <= '0;
      err_cnt      <= '0;
    end else begin
      r_vld    <= {r_vld[0], en};
      mismatch <= w_cmp & w_fail;
      if (w_cmp) begin
        if (chk_cnt != CNT_MAX) chk_cnt <= chk_cnt + CNT_W'(1);
        if (w_fail) begin
          if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
          if (!sticky_err) begin
            sticky_err   <= 1'b1;
            first_err_op <= w_exp_op;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alsu_checker.sv
// Self-checking bench: a behavioural ALSU drives dut_out/leds; both checker configs are scored.
module tb_alsu_checker;

  logic        clk, rst_n, en;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0]  dut_out_a, dut_out_b;
  logic [15:0] dut_leds_a, dut_leds_b;
  logic        mis_a, mis_b, stk_a, stk_b;
  logic [2:0]  fop_a, fop_b;
  logic [15:0] chk_a, err_a;
  logic [1:0]  chk_b, err_b;

  alsu_checker u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .dut_out(dut_out_a), .dut_leds(dut_leds_a),
    .mismatch(mis_a), .sticky_err(stk_a), .first_err_op(fop_a), .chk_cnt(chk_a), .err_cnt(err_a)
  );

  alsu_checker #(.INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B), .opcode(opcode), .cin(cin),
    .serial_in(serial_in), .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .dut_out(dut_out_b), .dut_leds(dut_leds_b),
    .mismatch(mis_b), .sticky_err(stk_b), .first_err_op(fop_b), .chk_cnt(chk_b), .err_cnt(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a, b, op, cin, si, dir, ra, rb, ba, bb, en;
  } smp_t;

  typedef struct {
    smp_t s;
    int   eo_a, eo_b, el, chk;
  } dir_t;

  int   n_chk, n_err;
  int   g_out[2], g_leds[2], drv_out[2], drv_leds[2];
  int   e_chk[2], e_err[2], e_stk[2], e_fop[2], e_mis[2];
  int   cmax[2];
  int   flt_out, flt_leds;
  bit   stuck0;
  smp_t h0, h1;
  dir_t tbl[19];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit ref_invalid(smp_t s);
    return (s.op > 5) || ((s.ra != 0 || s.rb != 0) && s.op > 1);
  endfunction

  // Behavioural ALSU: next out from the previous sample and current out.
  function automatic int ref_out(bit pa, bit fa, smp_t s, int o);
    bit use_a;
    if (ref_invalid(s)) return 0;
    if (s.ba != 0 || s.bb != 0) return (s.ba != 0 && (s.bb == 0 || pa)) ? s.a : s.b;
    use_a = (s.ra != 0) && (s.rb == 0 || pa);
    case (s.op)
      0: if (s.ra != 0 || s.rb != 0) return use_a ? int'(s.a == 7) : int'(s.b == 7);
         else return s.a & s.b;
      1: if (s.ra != 0 || s.rb != 0) return use_a ? $countones(s.a) % 2 : $countones(s.b) % 2;
         else return s.a ^ s.b;
      2: return s.a + s.b + (fa ? s.cin : 0);
      3: return s.a * s.b;
      4: return (s.dir != 0) ? (o * 2 + s.si) % 64 : s.si * 32 + o / 2;
      5: return (s.dir != 0) ? (o * 2) % 64 + o / 32 : (o % 2) * 32 + o / 2;
      default: return 0;
    endcase
  endfunction

  function automatic smp_t cur_smp();
    smp_t s;
    s.a = int'(A); s.b = int'(B); s.op = int'(opcode); s.cin = int'(cin);
    s.si = int'(serial_in); s.dir = int'(direction); s.ra = int'(red_op_A);
    s.rb = int'(red_op_B); s.ba = int'(bypass_A); s.bb = int'(bypass_B); s.en = int'(en);
    return s;
  endfunction

  function automatic smp_t mk(int a, int b, int op, int cn, int si, int dir,
                              int ra, int rb, int ba, int bb);
    smp_t s;
    s.a = a; s.b = b; s.op = op; s.cin = cn; s.si = si; s.dir = dir;
    s.ra = ra; s.rb = rb; s.ba = ba; s.bb = bb; s.en = 1;
    return s;
  endfunction

  task automatic apply(input smp_t s);
    A = 3'(s.a); B = 3'(s.b); opcode = 3'(s.op); cin = 1'(s.cin); serial_in = 1'(s.si);
    direction = 1'(s.dir); red_op_A = 1'(s.ra); red_op_B = 1'(s.rb);
    bypass_A = 1'(s.ba); bypass_B = 1'(s.bb); en = 1'(s.en);
  endtask

  task automatic drive_dut();
    for (int c = 0; c < 2; c++) begin
      drv_out[c]  = ((g_out[c] ^ flt_out) & 63) & (stuck0 ? 62 : 63);
      drv_leds[c] = (g_leds[c] ^ flt_leds) & 16'hFFFF;
    end
    dut_out_a  = 6'(drv_out[0]);  dut_out_b  = 6'(drv_out[1]);
    dut_leds_a = 16'(drv_leds[0]); dut_leds_b = 16'(drv_leds[1]);
  endtask

  task automatic model_reset();
    smp_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    z.en = 0;
    h0 = z; h1 = z;
    for (int c = 0; c < 2; c++) begin
      g_out[c] = 0; g_leds[c] = 0;
      e_chk[c] = 0; e_err[c] = 0; e_stk[c] = 0; e_fop[c] = 0; e_mis[c] = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mis_a"}, 32'(mis_a), 0); check({tag, "_stk_a"}, 32'(stk_a), 0);
    check({tag, "_fop_a"}, 32'(fop_a), 0); check({tag, "_chk_a"}, 32'(chk_a), 0);
    check({tag, "_err_a"}, 32'(err_a), 0); check({tag, "_mis_b"}, 32'(mis_b), 0);
    check({tag, "_stk_b"}, 32'(stk_b), 0); check({tag, "_fop_b"}, 32'(fop_b), 0);
    check({tag, "_chk_b"}, 32'(chk_b), 0); check({tag, "_err_b"}, 32'(err_b), 0);
    check({tag, "_exp_out"}, 32'(u_a.u_model.r_exp_out), 0);
    check({tag, "_exp_leds"}, 32'(u_a.u_model.r_exp_leds), 0);
  endtask

  // One clock: score the compare due at this edge, advance the ALSU, check, redrive.
  task automatic cycle();
    smp_t cur;
    bit   fail;
    @(posedge clk);
    cur = cur_smp();
    for (int c = 0; c < 2; c++) begin
      fail     = (drv_out[c] != g_out[c]) || (drv_leds[c] != g_leds[c]);
      e_mis[c] = (h1.en != 0 && fail) ? 1 : 0;
      if (h1.en != 0) begin
        if (e_chk[c] < cmax[c]) e_chk[c]++;
        if (fail) begin
          if (e_err[c] < cmax[c]) e_err[c]++;
          if (e_stk[c] == 0) begin e_stk[c] = 1; e_fop[c] = h1.op; end
        end
      end
      if (ref_invalid(h0)) g_leds[c] = (~g_leds[c]) & 16'hFFFF;
      else                 g_leds[c] = 0;
      g_out[c] = ref_out(c == 0, c == 0, h0, g_out[c]);
    end
    h1 = h0; h0 = cur;
    #1;
    check("mis_a", 32'(mis_a), e_mis[0]); check("stk_a", 32'(stk_a), e_stk[0]);
    check("fop_a", 32'(fop_a), e_fop[0]); check("chk_a", 32'(chk_a), e_chk[0]);
    check("err_a", 32'(err_a), e_err[0]); check("mis_b", 32'(mis_b), e_mis[1]);
    check("stk_b", 32'(stk_b), e_stk[1]); check("fop_b", 32'(fop_b), e_fop[1]);
    check("chk_b", 32'(chk_b), e_chk[1]); check("err_b", 32'(err_b), e_err[1]);
    check("exp_out_a", 32'(u_a.u_model.r_exp_out), g_out[0]);
    check("exp_leds_a", 32'(u_a.u_model.r_exp_leds), g_leds[0]);
    check("exp_out_b", 32'(u_b.u_model.r_exp_out), g_out[1]);
    drive_dut();
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    cmax[0] = 65535; cmax[1] = 3;
    flt_out = 0; flt_leds = 0; stuck0 = 1'b0;
    rst_n = 1'b0;
    model_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    en = 1'b0;
    drive_dut();

    //            A  B op cin si dir rA rB bA bB     out_a out_b leds  chk
    tbl[0]  = '{mk(3, 5, 2, 1, 0, 0, 0, 0, 0, 0),   9,  8, 16'h0000, 1};
    tbl[1]  = '{mk(0, 0, 6, 0, 0, 0, 0, 0, 0, 0),   0,  0, 16'hFFFF, 1};
    tbl[2]  = '{mk(0, 0, 6, 0, 0, 0, 0, 0, 0, 0),   0,  0, 16'h0000, 1};
    tbl[3]  = '{mk(0, 0, 6, 0, 0, 0, 0, 0, 0, 0),   0,  0, 16'hFFFF, 1};
    tbl[4]  = '{mk(0, 0, 6, 0, 0, 0, 0, 0, 0, 0),   0,  0, 16'h0000, 1};
    tbl[5]  = '{mk(0, 0, 4, 0, 1, 1, 0, 0, 0, 0),   1,  1, 16'h0000, 0};
    tbl[6]  = '{mk(0, 0, 4, 0, 0, 1, 0, 0, 0, 0),   2,  2, 16'h0000, 0};
    tbl[7]  = '{mk(0, 0, 4, 0, 0, 1, 0, 0, 0, 0),   4,  4, 16'h0000, 0};
    tbl[8]  = '{mk(0, 0, 4, 0, 0, 1, 0, 0, 0, 0),   8,  8, 16'h0000, 0};
    tbl[9]  = '{mk(0, 0, 4, 0, 0, 1, 0, 0, 0, 0),  16, 16, 16'h0000, 0};
    tbl[10] = '{mk(0, 0, 4, 0, 1, 1, 0, 0, 0, 0),  33, 33, 16'h0000, 1};
    tbl[11] = '{mk(0, 0, 5, 0, 0, 1, 0, 0, 0, 0),   3,  3, 16'h0000, 1};
    tbl[12] = '{mk(0, 0, 4, 0, 1, 0, 0, 0, 0, 0),  33, 33, 16'h0000, 1};
    tbl[13] = '{mk(2, 7, 0, 0, 0, 0, 0, 0, 1, 1),   2,  7, 16'h0000, 1};
    tbl[14] = '{mk(2, 7, 2, 0, 0, 0, 1, 0, 0, 0),   0,  0, 16'hFFFF, 1};
    tbl[15] = '{mk(2, 7, 2, 0, 0, 0, 1, 0, 1, 1),   0,  0, 16'h0000, 1};
    tbl[16] = '{mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0),   1,  1, 16'h0000, 1};
    tbl[17] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   0,  0, 16'h0000, 0};
    tbl[18] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   0,  0, 16'h0000, 0};

    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed walk: add, invalid blink, shift/rotate history, bypass, stuck-at-0 on bit0.
    for (int i = 0; i <= 19; i++) begin
      if (i < 19) apply(tbl[i].s);
      if (i == 17) stuck0 = 1'b1;
      cycle();
      if (i > 0 && tbl[i-1].chk != 0) begin
        check("dir_out_a", 32'(u_a.u_model.r_exp_out), tbl[i-1].eo_a);
        check("dir_out_b", 32'(u_b.u_model.r_exp_out), tbl[i-1].eo_b);
        check("dir_leds", 32'(u_a.u_model.r_exp_leds), tbl[i-1].el);
      end
    end
    stuck0 = 1'b0;
    check("stuck_err_a", 32'(err_a), 1);
    check("stuck_stk_a", 32'(stk_a), 1);
    check("stuck_fop_a", 32'(fop_a), 0);
    check("stuck_err_b", 32'(err_b), 1);

    // Random traffic with occasional en drops and corrupted responses.
    for (int i = 0; i < 300; i++) begin
      A = 3'($urandom_range(0, 7)); B = 3'($urandom_range(0, 7));
      opcode = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      cin = 1'($urandom_range(0, 1)); serial_in = 1'($urandom_range(0, 1));
      direction = 1'($urandom_range(0, 1));
      red_op_A = ($urandom_range(0, 5) == 0); red_op_B = ($urandom_range(0, 5) == 0);
      bypass_A = ($urandom_range(0, 5) == 0); bypass_B = ($urandom_range(0, 5) == 0);
      en = ($urandom_range(0, 9) != 0);
      flt_out  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 63)) : 0;
      flt_leds = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 65535)) : 0;
      cycle();
    end

    // Saturation: five consecutive forced mismatches.
    flt_out = 0; flt_leds = 0; en = 1'b1;
    repeat (2) cycle();
    flt_out = 1;
    repeat (5) cycle();
    flt_out = 0;
    cycle();
    check("sat_err_b", 32'(err_b), 3);
    check("sat_chk_b", 32'(chk_b), 3);

    // Asynchronous reset mid-stream, then the compare pipe refills.
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    drive_dut();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    cycle(); check("refill_1", 32'(chk_a), 0);
    cycle(); check("refill_2", 32'(chk_a), 0);
    cycle(); check("refill_3", 32'(chk_a), 1);
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
